// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// rs232_pkg : FSM state encoding, parity-mode constants and vote helper
// Rev 1.0
// ============================================================================
package rs232_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_rx_cfg_if.sv
`default_nettype none
// ============================================================================
// rs232_rx_cfg_if : serial line and received-word handshake of the receiver
// Rev 1.0
// ============================================================================
interface rs232_rx_cfg_if #(
  parameter int pDATA_W = 8
) ();

  logic               iSerial;
  logic [pDATA_W-1:0] oRxD;
  logic               oRxValid;
  logic               iRxReady;
  logic               oParityErr;
  logic               oFrameErr;
  logic               oOverrun;

  modport master (
    input  iSerial,
    input  iRxReady,
    output oRxD,
    output oRxValid,
    output oParityErr,
    output oFrameErr,
    output oOverrun
  );

  modport slave (
    output iSerial,
    output iRxReady,
    input  oRxD,
    input  oRxValid,
    input  oParityErr,
    input  oFrameErr,
    input  oOverrun
  );

endinterface
`default_nettype wire

// File: rtl/rs232_sample.sv
`default_nettype none
// ============================================================================
// rs232_sample : 2-flop line synchronizer, falling-edge detect, 3-sample vote
// Rev 1.0
// ============================================================================
module rs232_sample
  import rs232_pkg::*;
#(
  parameter int pCLK_PER_BIT = 434,
  parameter int CNT_W        = $clog2(pCLK_PER_BIT)
) (
  input  wire logic             Clk,
  input  wire logic             Rst,
  input  wire logic             serial_in,
  input  wire logic [CNT_W-1:0] cell_cnt,
  output logic                  fall,
  output logic                  bit_val,
  output logic                  bit_done
);

  localparam int              HALF  = pCLK_PER_BIT / 2;
  localparam logic [CNT_W-1:0] SMP_A = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP_B = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP_C = CNT_W'(HALF + 1);

  logic sync_a;
  logic sync_b;
  logic sync_prev;
  logic smp_a;
  logic smp_b;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync_a    <= 1'b1;
      sync_b    <= 1'b1;
      sync_prev <= 1'b1;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
    end else begin
      sync_a    <= serial_in;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      if (cell_cnt == SMP_A) smp_a <= sync_b;
      if (cell_cnt == SMP_B) smp_b <= sync_b;
    end
  end

  // Third sample is the live synchronized bit, so the vote resolves at H+1.
  assign fall     = sync_prev & ~sync_b;
  assign bit_done = (cell_cnt == SMP_C);
  assign bit_val  = maj3(smp_a, smp_b, sync_b);

endmodule
`default_nettype wire

// File: rtl/rs232_rx_cfg.sv
`default_nettype none
// ============================================================================
// rs232_rx_cfg : configurable RS-232 receiver with parity/stop checks and hold
// Rev 1.0
// ============================================================================
module rs232_rx_cfg
  import rs232_pkg::*;
#(
  parameter int pDATA_W      = 8,
  parameter int pCLK_PER_BIT = 434,
  parameter int pPARITY      = 0,
  parameter int pSTOP_BITS   = 1
) (
  input wire logic         Clk,
  input wire logic         Rst,
  rs232_rx_cfg_if.master   bus
);

  localparam int CNT_W = $clog2(pCLK_PER_BIT);
  localparam int BIT_W = 4;

  if (pDATA_W < 5 || pDATA_W > 9) begin : g_bad_data_w
    $error("rs232_rx_cfg: pDATA_W must be 5..9");
  end
  if (pCLK_PER_BIT < 8) begin : g_bad_clk_per_bit
    $error("rs232_rx_cfg: pCLK_PER_BIT must be >= 8");
  end
  if (pPARITY != PAR_NONE && pPARITY != PAR_ODD && pPARITY != PAR_EVEN) begin : g_bad_parity
    $error("rs232_rx_cfg: pPARITY must be 0, 1 or 2");
  end
  if (pSTOP_BITS != 1 && pSTOP_BITS != 2) begin : g_bad_stop_bits
    $error("rs232_rx_cfg: pSTOP_BITS must be 1 or 2");
  end

  localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(pCLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(pDATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(pSTOP_BITS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cell_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [pDATA_W-1:0] shreg;
  logic               par_err_acc;
  logic               frm_err_acc;

  logic [pDATA_W-1:0] rxd;
  logic               rx_valid;
  logic               par_err;
  logic               frm_err;
  logic               overrun;

  logic fall;
  logic bit_val;
  logic bit_done;
  logic last_data;
  logic last_stop;
  logic par_expect;

  logic cnt_clr;
  logic shift_en;
  logic par_en;
  logic stop_en;
  logic frame_done;

  rs232_sample #(
    .pCLK_PER_BIT (pCLK_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_sample (
    .Clk       (Clk),
    .Rst       (Rst),
    .serial_in (bus.iSerial),
    .cell_cnt  (cell_cnt),
    .fall      (fall),
    .bit_val   (bit_val),
    .bit_done  (bit_done)
  );

  assign last_data  = (bit_cnt == DATA_LAST);
  assign last_stop  = (bit_cnt == STOP_LAST);
  assign par_expect = (pPARITY == PAR_ODD) ? ~(^shreg) : (^shreg);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (fall) state_nxt = ST_START;
      ST_START:  if (bit_done) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_done && last_data)
                   state_nxt = (pPARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (bit_done) state_nxt = ST_STOP;
      ST_STOP:   if (bit_done && last_stop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr    = (state == ST_IDLE) || (state_nxt == ST_IDLE);
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_DATA:   shift_en = bit_done;
      ST_PARITY: par_en   = bit_done;
      ST_STOP: begin
        stop_en    = bit_done;
        frame_done = bit_done && last_stop;
      end
      default: ;
    endcase
  end

  // Counter is forced to 0 on the way back to IDLE so an early start edge
  // arriving during the tail of the stop cell begins a clean cell.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cell_cnt <= '0;
    end else if (cnt_clr || cell_cnt == CELL_LAST) begin
      cell_cnt <= '0;
    end else begin
      cell_cnt <= cell_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bit_cnt <= '0;
    end else if (state == ST_IDLE || state_nxt != state) begin
      bit_cnt <= '0;
    end else if (shift_en || stop_en) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shreg       <= '0;
      par_err_acc <= 1'b0;
      frm_err_acc <= 1'b0;
    end else begin
      if (shift_en) shreg <= {bit_val, shreg[pDATA_W-1:1]};
      if (state == ST_IDLE) begin
        par_err_acc <= 1'b0;
        frm_err_acc <= 1'b0;
      end else begin
        if (par_en) par_err_acc <= (bit_val != par_expect);
        if (stop_en && !bit_val) frm_err_acc <= 1'b1;
      end
    end
  end

  // A completed frame may load only when the holding register is empty or
  // is being emptied on this very edge; otherwise it is dropped.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rxd      <= '0;
      rx_valid <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= frame_done && rx_valid && !bus.iRxReady;
      if (frame_done && (!rx_valid || bus.iRxReady)) begin
        rxd      <= shreg;
        par_err  <= par_err_acc;
        frm_err  <= frm_err_acc | ~bit_val;
        rx_valid <= 1'b1;
      end else if (rx_valid && bus.iRxReady) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign bus.oRxD       = rxd;
  assign bus.oRxValid   = rx_valid;
  assign bus.oParityErr = par_err;
  assign bus.oFrameErr  = frm_err;
  assign bus.oOverrun   = overrun;

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx_cfg.sv
`default_nettype none
// ============================================================================
// tb_rs232_rx_cfg : directed bench for rs232_rx_cfg (no-parity and even-parity)
// Rev 1.0
// ============================================================================
module tb_rs232_rx_cfg;

  localparam int CPB = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic line = 1'b1;
  logic sel_ev = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int         vld_cycles = 0;
  int         first_vld  = 0;
  int         xfers      = 0;
  int         ovr        = 0;
  logic [7:0] cap_d      = 8'h00;
  logic       cap_pe     = 1'b0;
  logic       cap_fe     = 1'b0;

  rs232_rx_cfg_if #(.pDATA_W(8)) bus_np ();
  rs232_rx_cfg_if #(.pDATA_W(8)) bus_ev ();

  assign bus_np.iSerial = sel_ev ? 1'b1 : line;
  assign bus_ev.iSerial = sel_ev ? line : 1'b1;

  rs232_rx_cfg #(
    .pDATA_W(8), .pCLK_PER_BIT(CPB), .pPARITY(0), .pSTOP_BITS(1)
  ) u_dut_np (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_np)
  );

  rs232_rx_cfg #(
    .pDATA_W(8), .pCLK_PER_BIT(CPB), .pPARITY(2), .pSTOP_BITS(2)
  ) u_dut_ev (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_ev)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus_np.oRxValid) begin
      if (vld_cycles == 0) first_vld = cyc;
      vld_cycles = vld_cycles + 1;
      cap_d  = bus_np.oRxD;
      cap_pe = bus_np.oParityErr;
      cap_fe = bus_np.oFrameErr;
    end
    if (bus_np.oRxValid && bus_np.iRxReady) xfers = xfers + 1;
    if (bus_np.oOverrun) ovr = ovr + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // cells[0] goes out first; flip_cell inverts the line for one clock at sample H.
  task automatic send_cells(input logic [15:0] cells, input int n, input int flip_cell);
    for (int i = 0; i < n; i++) begin
      line = cells[i];
      if (i == flip_cell) begin
        tick(9);
        line = ~cells[i];
        tick(1);
        line = cells[i];
        tick(6);
      end else begin
        tick(CPB);
      end
    end
    line = 1'b1;
  endtask

  function automatic logic [15:0] fr_np(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr_ev(input logic [7:0] d, input logic p, input logic stop2);
    return {4'b0, stop2, 1'b1, p, d, 1'b0};
  endfunction

  initial begin
    int v0, x0, o0, t0;
    bus_np.iRxReady = 1'b1;
    bus_ev.iRxReady = 1'b0;

    tick(3);
    check_eq("rst_hold_valid", bus_np.oRxValid, 1'b0);
    Rst = 1'b1;
    tick(4);
    check_eq("rst_valid",   bus_np.oRxValid,   1'b0);
    check_eq("rst_rxd",     bus_np.oRxD,       8'h00);
    check_eq("rst_perr",    bus_np.oParityErr, 1'b0);
    check_eq("rst_ferr",    bus_np.oFrameErr,  1'b0);
    check_eq("rst_ovr",     bus_np.oOverrun,   1'b0);
    check_eq("rst_ev_valid", bus_ev.oRxValid,  1'b0);

    // Basic frame with consumer always ready.
    v0 = vld_cycles; o0 = ovr; t0 = cyc;
    send_cells(fr_np(8'hA5, 1'b1), 10, -1);
    tick(2 * CPB);
    check_eq("a5_vld_cycles", vld_cycles - v0, 1);
    check_eq("a5_latency",    first_vld - t0, 16 * 9 + 13);
    check_eq("a5_data",       cap_d, 8'hA5);
    check_eq("a5_perr",       cap_pe, 1'b0);
    check_eq("a5_ferr",       cap_fe, 1'b0);
    check_eq("a5_no_ovr",     ovr - o0, 0);

    // Framing error, then a clean frame.
    v0 = vld_cycles;
    send_cells(fr_np(8'h55, 1'b0), 10, -1);
    tick(2 * CPB);
    check_eq("55_data",  cap_d, 8'h55);
    check_eq("55_ferr",  cap_fe, 1'b1);
    send_cells(fr_np(8'h12, 1'b1), 10, -1);
    tick(2 * CPB);
    check_eq("12_data",  cap_d, 8'h12);
    check_eq("12_ferr",  cap_fe, 1'b0);
    check_eq("55_12_cnt", vld_cycles - v0, 2);

    // Short low glitch, then a data bit with a one-clock flip at sample H.
    v0 = vld_cycles;
    line = 1'b0;
    tick(4);
    line = 1'b1;
    tick(4 * CPB);
    check_eq("glitch_no_word", vld_cycles - v0, 0);
    send_cells(fr_np(8'h96, 1'b1), 10, 3);
    tick(2 * CPB);
    check_eq("flip_data", cap_d, 8'h96);
    check_eq("flip_cnt",  vld_cycles - v0, 1);

    // Overrun: held word survives, second frame is dropped.
    bus_np.iRxReady = 1'b0;
    o0 = ovr; x0 = xfers;
    send_cells(fr_np(8'h11, 1'b1), 10, -1);
    check_eq("ovr_first_valid", bus_np.oRxValid, 1'b1);
    check_eq("ovr_first_data",  bus_np.oRxD, 8'h11);
    send_cells(fr_np(8'h22, 1'b1), 10, -1);
    tick(CPB);
    check_eq("ovr_held_data", bus_np.oRxD, 8'h11);
    check_eq("ovr_pulses",    ovr - o0, 1);
    bus_np.iRxReady = 1'b1;
    tick(4);
    bus_np.iRxReady = 1'b0;
    tick(2 * CPB);
    check_eq("ovr_drained",   bus_np.oRxValid, 1'b0);
    check_eq("ovr_one_xfer",  xfers - x0, 1);

    // Ready asserted exactly on the completion cycle of the next frame.
    send_cells(fr_np(8'h33, 1'b1), 10, -1);
    tick(CPB);
    check_eq("same_held_33", bus_np.oRxD, 8'h33);
    o0 = ovr;
    fork
      send_cells(fr_np(8'h22, 1'b1), 10, -1);
      begin
        tick(16 * 9 + 12);
        bus_np.iRxReady = 1'b1;
        tick(1);
        bus_np.iRxReady = 1'b0;
      end
    join
    tick(CPB);
    check_eq("same_cyc_data",  bus_np.oRxD, 8'h22);
    check_eq("same_cyc_valid", bus_np.oRxValid, 1'b1);
    check_eq("same_cyc_no_ovr", ovr - o0, 0);
    bus_np.iRxReady = 1'b1;
    tick(4);

    // Even parity, two stop bits.
    sel_ev = 1'b1;
    send_cells(fr_ev(8'h3C, 1'b1, 1'b1), 12, -1);
    tick(CPB);
    check_eq("par1_valid", bus_ev.oRxValid, 1'b1);
    check_eq("par1_data",  bus_ev.oRxD, 8'h3C);
    check_eq("par1_perr",  bus_ev.oParityErr, 1'b1);
    check_eq("par1_ferr",  bus_ev.oFrameErr, 1'b0);
    bus_ev.iRxReady = 1'b1;
    tick(2);
    bus_ev.iRxReady = 1'b0;
    check_eq("par_accepted", bus_ev.oRxValid, 1'b0);
    send_cells(fr_ev(8'h3C, 1'b0, 1'b1), 12, -1);
    tick(CPB);
    check_eq("par0_data", bus_ev.oRxD, 8'h3C);
    check_eq("par0_perr", bus_ev.oParityErr, 1'b0);
    bus_ev.iRxReady = 1'b1;
    tick(2);
    bus_ev.iRxReady = 1'b0;
    send_cells(fr_ev(8'h5A, 1'b0, 1'b0), 12, -1);
    tick(CPB);
    check_eq("stop2_data", bus_ev.oRxD, 8'h5A);
    check_eq("stop2_perr", bus_ev.oParityErr, 1'b0);
    check_eq("stop2_ferr", bus_ev.oFrameErr, 1'b1);
    sel_ev = 1'b0;
    tick(CPB);

    // Reset during data bit 3 with a word held.
    bus_np.iRxReady = 1'b0;
    send_cells(fr_np(8'h5A, 1'b1), 10, -1);
    tick(CPB);
    check_eq("prerst_valid", bus_np.oRxValid, 1'b1);
    fork
      send_cells(fr_np(8'h6B, 1'b1), 10, -1);
      begin
        tick(16 * 4 + 8);
        Rst = 1'b0;
        #1;
        check_eq("midrst_valid", bus_np.oRxValid,   1'b0);
        check_eq("midrst_rxd",   bus_np.oRxD,       8'h00);
        check_eq("midrst_perr",  bus_np.oParityErr, 1'b0);
        check_eq("midrst_ferr",  bus_np.oFrameErr,  1'b0);
        check_eq("midrst_ovr",   bus_np.oOverrun,   1'b0);
      end
    join
    tick(8);
    Rst = 1'b1;
    bus_np.iRxReady = 1'b1;
    tick(2 * CPB);
    v0 = vld_cycles;
    send_cells(fr_np(8'h7E, 1'b1), 10, -1);
    tick(2 * CPB);
    check_eq("post_rst_data", cap_d, 8'h7E);
    check_eq("post_rst_cnt",  vld_cycles - v0, 1);
    check_eq("post_rst_ferr", cap_fe, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
